// File: rtl/main_memory.sv
// main_memory: word memory with programmable access latency; in clk rst data addr wr, out response out
module main_memory #(
  parameter int DEPTH     = 1024,
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data,
  input  logic [31:0] addr,
  input  logic        wr,
  output logic        response,
  output logic [31:0] out
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t               state;
  logic [31:0]          mem [DEPTH];
  logic [ADDR_BITS-1:0] l_addr;
  logic [31:0]          l_data;
  logic                 l_wr;
  logic [7:0]           cnt;
  logic                 mismatch;
  logic                 commit;
  logic                 unused_addr;
  assign unused_addr = ^addr[31:ADDR_BITS];
  assign mismatch = addr[ADDR_BITS-1:0] != l_addr || wr != l_wr || (wr && data != l_data);
  assign commit = !rst && state == BUSY && !mismatch && cnt == 8'd1;
  assign response = state == RESP;
  always_ff @(posedge clk)
    if (commit && l_wr) mem[l_addr] <= l_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
      out   <= 32'd0;
    end else if (state == IDLE || (state == BUSY && mismatch)) begin
      l_addr <= addr[ADDR_BITS-1:0];
      l_data <= data;
      l_wr   <= wr;
      cnt    <= 8'(LATENCY);
      state  <= BUSY;
    end else if (state == BUSY && cnt == 8'd1) begin
      out   <= l_wr ? l_data : mem[l_addr];
      state <= RESP;
    end else if (state == BUSY) begin
      cnt <= cnt - 8'd1;
    end else begin
      state <= IDLE;
    end
  end
endmodule
